// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, FSM state type and round helper functions.
//   K        : the 64 round constants, K[0] first.
//   IV       : standard initial hash value, h0 in bits 255:224.
//   state_e  : nonce search FSM states (LOAD2/ROUND2/FINAL2 are only used by the
//              double-hash build, see SHA256_DOUBLE_HASH_EN in sha256_nonce_miner).
//   big_sigma0/1, small_sigma0/1, ch, maj : the SHA-256 logical functions.
package sha256_pkg;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   typedef enum logic [3:0] {
      StIdle,
      StLoad,
      StRound,
      StFinal,
      StLoad2,
      StRound2,
      StFinal2,
      StCheck,
      StDone
   } state_e;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round plus the next schedule word.
//   state_in  : a..h before the round, a in bits 255:224.
//   kt, wt    : round constant and schedule word for this round (W[t]).
//   w1,w9,w14 : W[t+1], W[t+9], W[t+14] from the 16-word sliding window.
//   state_out : a..h after the round.
//   w_next    : W[t+16], to be shifted into the window.
module sha256_round
   import sha256_pkg::*;
(
   input  logic [255:0] state_in,
   input  logic [31:0]  kt,
   input  logic [31:0]  wt,
   input  logic [31:0]  w1,
   input  logic [31:0]  w9,
   input  logic [31:0]  w14,
   output logic [255:0] state_out,
   output logic [31:0]  w_next
);

   logic [31:0] a, b, c, d, e, f, g, h;
   logic [31:0] t1, t2;

   always_comb begin
      {a, b, c, d, e, f, g, h} = state_in;
      t1        = h + big_sigma1(e) + ch(e, f, g) + kt + wt;
      t2        = big_sigma0(a) + maj(a, b, c);
      state_out = {t1 + t2, a, b, c, d + t1, e, f, g};
      w_next    = small_sigma1(w14) + w9 + small_sigma0(w1) + wt;
   end

endmodule

// File: rtl/sha256_nonce_miner.sv
// sha256_nonce_miner: iterative SHA-256 nonce search over an inclusive, possibly wrapping,
// range with a fixed stride. Each nonce is written into one word of the final block, the
// block is compressed from the midstate (one round per cycle), and the digest's leading
// zero count is compared against the runtime difficulty. The first winner, or the last
// nonce tried when the range is exhausted, is returned over a ready/valid handshake.
//
// Optional feature: define SHA256_DOUBLE_HASH_EN to hash the first digest a second time
// (SHA-256d); the second digest is then the one compared and reported.
//
// Ports:
//   clock, reset           : rising-edge clock, asynchronous active-low reset.
//   start, abort           : start request (honoured in IDLE only), cancel search.
//   midstate, block_tmpl   : initial h0..h7 and padded final block, latched on start.
//   nonce_start, nonce_end : inclusive search bounds.
//   difficulty             : required leading zero bits of the digest.
//   busy                   : search in progress or result pending.
//   result_valid/ready     : result handshake.
//   result_found/nonce/hash: winner flag, nonce, and its digest.
module sha256_nonce_miner
   import sha256_pkg::*;
#(
   parameter int unsigned NONCE_W      = 32,
   parameter int unsigned NONCE_OFFSET = 3,
   parameter int unsigned NONCE_STEP   = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [255:0]       midstate,
   input  logic [511:0]       block_tmpl,
   input  logic [NONCE_W-1:0] nonce_start,
   input  logic [NONCE_W-1:0] nonce_end,
   input  logic [7:0]         difficulty,
   output logic               busy,
   output logic               result_valid,
   input  logic               result_ready,
   output logic               result_found,
   output logic [NONCE_W-1:0] result_nonce,
   output logic [255:0]       result_hash
);

   localparam int unsigned NonceShift = 32 * (15 - NONCE_OFFSET);
   localparam logic [511:0] NonceMask = {480'b0, 32'hffffffff} << NonceShift;

   state_e             state_q, state_d;
   logic [5:0]         round_q, round_d;
   logic [255:0]       work_q, work_d;     // a..h
   logic [511:0]       w_q, w_d;           // W[t..t+15], W[t] in bits 511:480
   logic [255:0]       hash_q, hash_d;     // chaining value, then digest
   logic [255:0]       mid_q, mid_d;
   logic [511:0]       tmpl_q, tmpl_d;     // template with the nonce word cleared
   logic [NONCE_W-1:0] nonce_q, nonce_d;
   logic [NONCE_W-1:0] end_q, end_d;
   logic [7:0]         diff_q, diff_d;
   logic               busy_q, busy_d;
   logic               valid_q, valid_d;
   logic               found_q, found_d;
   logic [NONCE_W-1:0] rnonce_q, rnonce_d;
   logic [255:0]       rhash_q, rhash_d;

   logic [255:0]       round_state;
   logic [31:0]        round_w;
   logic [511:0]       w_load;
   logic [255:0]       digest_sum;
   logic [8:0]         lzc;
   logic [NONCE_W-1:0] remain;
   logic               exhausted;
   logic               match;

   sha256_round u_round (
      .state_in  (work_q),
      .kt        (K[round_q]),
      .wt        (w_q[511:480]),
      .w1        (w_q[479:448]),
      .w9        (w_q[223:192]),
      .w14       (w_q[63:32]),
      .state_out (round_state),
      .w_next    (round_w)
   );

   // Message block for the current nonce; the nonce word of tmpl_q is already zero.
   always_comb begin
      w_load = tmpl_q | ({480'b0, 32'(nonce_q)} << NonceShift);
   end

   always_comb begin
      digest_sum = '0;
      for (int i = 0; i < 8; i++) begin
         digest_sum[32*i +: 32] = hash_q[32*i +: 32] + work_q[32*i +: 32];
      end
   end

   // Leading zero count from bit 255; the highest set bit is the last one to assign.
   always_comb begin
      lzc = 9'd256;
      for (int i = 0; i < 256; i++) begin
         if (hash_q[i]) begin
            lzc = 9'(255 - i);
         end
      end
   end

   // Modular distance to the end bound handles ranges that wrap through zero.
   always_comb begin
      remain    = end_q - nonce_q;
      exhausted = 32'(remain) < NONCE_STEP;
      match     = lzc >= {1'b0, diff_q};
   end

   always_comb begin
      state_d  = state_q;
      round_d  = round_q;
      work_d   = work_q;
      w_d      = w_q;
      hash_d   = hash_q;
      mid_d    = mid_q;
      tmpl_d   = tmpl_q;
      nonce_d  = nonce_q;
      end_d    = end_q;
      diff_d   = diff_q;
      busy_d   = busy_q;
      valid_d  = valid_q;
      found_d  = found_q;
      rnonce_d = rnonce_q;
      rhash_d  = rhash_q;

      if (abort && (state_q != StIdle)) begin
         // Abort wins over everything, including a result transfer in the same cycle.
         state_d = StIdle;
         busy_d  = 1'b0;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  mid_d   = midstate;
                  tmpl_d  = block_tmpl & ~NonceMask;
                  nonce_d = nonce_start;
                  end_d   = nonce_end;
                  diff_d  = difficulty;
                  busy_d  = 1'b1;
                  state_d = StLoad;
               end
            end
            StLoad: begin
               w_d     = w_load;
               work_d  = mid_q;
               hash_d  = mid_q;
               round_d = '0;
               state_d = StRound;
            end
            StRound: begin
               work_d  = round_state;
               w_d     = {w_q[479:0], round_w};
               round_d = round_q + 6'd1;
               if (round_q == 6'd63) begin
                  state_d = StFinal;
               end
            end
            StFinal: begin
               hash_d = digest_sum;
`ifdef SHA256_DOUBLE_HASH_EN
               state_d = StLoad2;
`else
               state_d = StCheck;
`endif
            end
`ifdef SHA256_DOUBLE_HASH_EN
            StLoad2: begin
               // Second pass hashes the 32-byte digest as a single padded block.
               w_d     = {hash_q, 32'h80000000, 192'h0, 32'h00000100};
               work_d  = IV;
               hash_d  = IV;
               round_d = '0;
               state_d = StRound2;
            end
            StRound2: begin
               work_d  = round_state;
               w_d     = {w_q[479:0], round_w};
               round_d = round_q + 6'd1;
               if (round_q == 6'd63) begin
                  state_d = StFinal2;
               end
            end
            StFinal2: begin
               hash_d  = digest_sum;
               state_d = StCheck;
            end
`endif
            StCheck: begin
               if (match || exhausted) begin
                  found_d  = match;
                  rnonce_d = nonce_q;
                  rhash_d  = hash_q;
                  valid_d  = 1'b1;
                  state_d  = StDone;
               end else begin
                  nonce_d = nonce_q + NONCE_W'(NONCE_STEP);
                  state_d = StLoad;
               end
            end
            StDone: begin
               if (result_ready) begin
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end
            end
            default: begin
               state_d = StIdle;
               busy_d  = 1'b0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         round_q  <= '0;
         work_q   <= '0;
         w_q      <= '0;
         hash_q   <= '0;
         mid_q    <= '0;
         tmpl_q   <= '0;
         nonce_q  <= '0;
         end_q    <= '0;
         diff_q   <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         found_q  <= 1'b0;
         rnonce_q <= '0;
         rhash_q  <= '0;
      end else begin
         state_q  <= state_d;
         round_q  <= round_d;
         work_q   <= work_d;
         w_q      <= w_d;
         hash_q   <= hash_d;
         mid_q    <= mid_d;
         tmpl_q   <= tmpl_d;
         nonce_q  <= nonce_d;
         end_q    <= end_d;
         diff_q   <= diff_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         found_q  <= found_d;
         rnonce_q <= rnonce_d;
         rhash_q  <= rhash_d;
      end
   end

   assign busy         = busy_q;
   assign result_valid = valid_q;
   assign result_found = found_q;
   assign result_nonce = rnonce_q;
   assign result_hash  = rhash_q;

endmodule
